// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 16 {a,b,c,d} vectors onto a downstream
// 4-input combinational function and captures its output s_in. After each
// vector has been held for SETTLE cycles, the sample goes into a 16-bit
// truth table and a running ones count.
// Optional feature macro: SWEEP_CHECK_EN. When it is defined, the captured
// table is compared against EXPECTED. When it is undefined, mismatch is tied to 0.
`timescale 1ns/1ps

module truth_table_sweeper #(
    parameter int          SETTLE   = 1,        // legal range 1..15
    parameter logic [15:0] EXPECTED = 16'h0F2A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        s_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  ones,
    output logic        mismatch
);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(SETTLE - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [3:0]  hold_cnt;
    logic [15:0] table_q;
    logic [4:0]  ones_q;
    logic        sample;

    // The last cycle of each hold window is the one whose closing edge captures s_in.
    assign sample = (state == SWEEP) && (hold_cnt == HOLD_LAST);

    // State register.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in the design updates from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. start only matters in IDLE, and DONE always lasts exactly one cycle.
    // NOTE: the default is assigned before the case statement so that no path
    // leaves state_nxt unassigned. An unassigned path would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SWEEP;
            SWEEP:   if (sample && (idx == 4'd15)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep datapath: vector index, hold counter and capture registers.
    // The results are cleared only when a new sweep is accepted, so the last
    // table stays readable while the block is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= 4'd0;
            hold_cnt <= 4'd0;
            table_q  <= 16'd0;
            ones_q   <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    idx      <= 4'd0;
                    hold_cnt <= 4'd0;
                    if (start) begin
                        table_q <= 16'd0;
                        ones_q  <= 5'd0;
                    end
                end
                SWEEP: begin
                    if (sample) begin
                        table_q[idx] <= s_in;
                        ones_q       <= ones_q + {4'd0, s_in};
                        hold_cnt     <= 4'd0;
                        if (idx != 4'd15) idx <= idx + 4'd1;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                default: begin
                    idx      <= 4'd0;
                    hold_cnt <= 4'd0;
                end
            endcase
        end
    end

`ifdef SWEEP_CHECK_EN
    logic mismatch_q;

    // The comparator result is latched in DONE. It holds until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
        end else if (state == DONE) begin
            mismatch_q <= (table_q != EXPECTED);
        end else if ((state == IDLE) && start) begin
            mismatch_q <= 1'b0;
        end
    end

    // The table is already complete during the done cycle, so mismatch is
    // valid there as well as afterwards.
    assign mismatch = mismatch_q | ((state == DONE) && (table_q != EXPECTED));
`else
    assign mismatch = 1'b0;
`endif

    assign {a, b, c, d} = (state == SWEEP) ? idx : 4'd0;
    assign busy         = (state == SWEEP);
    assign done         = (state == DONE);
    assign table_out    = table_q;
    assign ones         = ones_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper. It uses two instances,
// SETTLE=1 and SETTLE=3. Each s_in is modelled as exp_3b (table 16'h0F2A),
// or as a constant 1. Expected results are queued when a sweep is started
// and popped when done fires.
`timescale 1ns/1ps

module tb_truth_table_sweeper;

`ifdef SWEEP_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    typedef struct {
        logic [15:0] tbl;
        logic [4:0]  ones;
        logic        mm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0;
    logic start3 = 1'b0;
    logic ones_mode = 1'b0;
    logic [15:0] golden = 16'h0F2A;

    logic a1, b1, c1, d1, busy1, done1, mm1, s1;
    logic a3, b3, c3, d3, busy3, done3, mm3, s3;
    logic [15:0] table1, table3;
    logic [4:0]  ones1, ones3;

    int sel = 1;
    logic [3:0]  v_vec;
    logic        v_busy, v_done, v_mm;
    logic [15:0] v_table;
    logic [4:0]  v_ones;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    int   vec_h[$];
    bit   busy_h[$];
    int   done_at[$];

    always #5 clk = ~clk;

    // exp_3b model, or s tied high
    assign s1 = ones_mode ? 1'b1 : golden[{a1, b1, c1, d1}];
    assign s3 = ones_mode ? 1'b1 : golden[{a3, b3, c3, d3}];

    truth_table_sweeper #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .s_in(s1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .table_out(table1), .ones(ones1), .mismatch(mm1)
    );

    truth_table_sweeper #(.SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .s_in(s3),
        .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
        .table_out(table3), .ones(ones3), .mismatch(mm3)
    );

    always_comb begin
        if (sel == 3) begin
            v_vec = {a3, b3, c3, d3}; v_busy = busy3; v_done = done3;
            v_table = table3; v_ones = ones3; v_mm = mm3;
        end else begin
            v_vec = {a1, b1, c1, d1}; v_busy = busy1; v_done = done1;
            v_table = table1; v_ones = ones1; v_mm = mm1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input bit all_ones);
        exp_t e;
        e.tbl  = all_ones ? 16'hFFFF : 16'h0F2A;
        e.ones = 5'd0;
        for (int i = 0; i < 16; i++) e.ones = e.ones + {4'd0, e.tbl[i]};
        e.mm   = CHECK ? (e.tbl != 16'h0F2A) : 1'b0;
        return e;
    endfunction

    task automatic drive_start(input logic v);
        if (sel == 3) start3 = v;
        else          start1 = v;
    endtask

    task automatic check_result();
        exp_t e;
        check("scoreboard_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("table_out", 32'(v_table), 32'(e.tbl));
            check("ones", 32'(v_ones), 32'(e.ones));
            check("mismatch", 32'(v_mm), 32'(e.mm));
        end
    endtask

    // Record the selected DUT once per cycle at the falling edge.
    // n = 0 is the cycle right after the start-accepting edge E0.
    task automatic observe(input int cycles, input int start_cycles, input int restart_at);
        vec_h.delete(); busy_h.delete(); done_at.delete();
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (n == start_cycles - 1) drive_start(1'b0);
            if (restart_at >= 0 && n == restart_at) drive_start(1'b1);
            if (restart_at >= 0 && n == restart_at + 1) drive_start(1'b0);
            vec_h.push_back(int'(v_vec));
            busy_h.push_back(v_busy);
            if (v_done) begin
                done_at.push_back(n);
                check_result();
            end
        end
    endtask

    task automatic check_sweep(input string tag, input int settle, input int n0);
        int errs = 0;
        for (int n = 0; n < 16 * settle; n++)
            if (vec_h[n0 + n] != n / settle || !busy_h[n0 + n]) errs++;
        check({tag, "_vectors"}, 32'(errs), 32'd0);
        check({tag, "_busy_at_done"}, 32'(busy_h[n0 + 16 * settle]), 32'd0);
        check({tag, "_vec_at_done"}, 32'(vec_h[n0 + 16 * settle]), 32'd0);
    endtask

    task automatic one_sweep(input string tag, input int settle, input int cycles,
                             input int restart_at, input bit all_ones);
        sb.push_back(model(all_ones));
        @(negedge clk);
        drive_start(1'b1);
        @(posedge clk);
        observe(cycles, 1, restart_at);
        check({tag, "_done_count"}, 32'(done_at.size()), 32'd1);
        if (done_at.size() != 0) check({tag, "_done_cycle"}, 32'(done_at[0]), 32'(16 * settle));
        check_sweep(tag, settle, 0);
    endtask

    initial begin
        bit found;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy1 | busy3), 32'd0);
        check("rst_done", 32'(done1 | done3), 32'd0);
        check("rst_vec", 32'({a1, b1, c1, d1, a3, b3, c3, d3}), 32'd0);
        check("rst_table", 32'(table1 | table3), 32'd0);
        check("rst_ones_mm", 32'({ones1, ones3, mm1, mm3}), 32'd0);
        rst_n = 1'b1;

        // exp_3b sweep, SETTLE=1
        sel = 1;
        one_sweep("exp3b_s1", 1, 24, -1, 1'b0);
        check("exp3b_s1_table_hold", 32'(v_table), 32'h0F2A);

        // s_in tied high: ones must reach 16 without wrapping
        ones_mode = 1'b1;
        one_sweep("ones_s1", 1, 24, -1, 1'b1);
        check("ones_s1_hold", 32'(v_ones), 32'd16);
        ones_mode = 1'b0;

        // SETTLE=3
        sel = 3;
        one_sweep("exp3b_s3", 3, 56, -1, 1'b0);
        sel = 1;

        // start re-pulsed at vector 5 is ignored
        one_sweep("restart", 1, 30, 5, 1'b0);

        // reset at vector 9
        @(negedge clk);
        drive_start(1'b1);
        @(posedge clk);
        @(negedge clk);
        drive_start(1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (v_vec == 4'd9) found = 1'b1;
            else @(negedge clk);
        end
        check("rst_mid_reached_vec9", 32'(found), 32'd1);
        check("rst_mid_partial_table", 32'(v_table), 32'h012A);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(v_busy), 32'd0);
        check("rst_mid_vec", 32'(v_vec), 32'd0);
        check("rst_mid_table", 32'(v_table), 32'd0);
        check("rst_mid_ones", 32'(v_ones), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        observe(20, 0, -1);
        check("rst_mid_no_done", 32'(done_at.size()), 32'd0);
        one_sweep("after_rst", 1, 24, -1, 1'b0);

        // start held high for 40 cycles: back-to-back sweeps
        repeat (3) sb.push_back(model(1'b0));
        @(negedge clk);
        drive_start(1'b1);
        @(posedge clk);
        observe(60, 40, -1);
        check("b2b_done_count", 32'(done_at.size()), 32'd3);
        if (done_at.size() >= 2) begin
            check("b2b_done1", 32'(done_at[0]), 32'd16);
            check("b2b_done2", 32'(done_at[1]), 32'd34);
        end
        check("b2b_idle_gap_busy", 32'(busy_h[17]), 32'd0);
        check("b2b_second_start", 32'({busy_h[18], vec_h[18][3:0]}), 32'h10);
        check_sweep("b2b_second", 1, 18);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
